multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS control sequencer: a Moore-style FSM that steps the shared datapath (single memory, single ALU, instruction register) through fetch, decode and per-opcode execute/memory/writeback phases, emitting one set of datapath strobes per cycle. It replaces one-shot opcode decoding for the multi-cycle core and sits between the instruction register (opcode source) and the datapath muxes/enables. Memory phases wait on a ready handshake. The block counts retired instructions.

## Interface
- No parameters; state encodings and opcodes come from the package.
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from instruction register, valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Branch  out  1 each  datapath strobes/selects
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub (compare), 10 funct-decoded
- PCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- instr_count  out  32  retired-instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP (JUMP only with macro). Outputs not listed are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready. Hold until mem_ready, then DECODE.
- DECODE: ALUSrcB=11, ALUOp=00; latch opcode into op_q. Next: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP (macro), other -> FETCH with illegal_op=1 and instr_done=1 (treated as NOP).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; op_q lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD=1, MemRead=1; hold until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1; hold until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 (datapath ANDs with zero) -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- instr_done=1 in MEMWB, ALUWB, BRANCH, JUMP, MEMWR&&mem_ready, DECODE-illegal. instr_count increments on instr_done, wraps 0xFFFFFFFF -> 0.
- Post-DECODE transitions use op_q, never the live opcode input.

## Timing
- Reset: next edge sets state=FETCH, op_q=0, instr_count=0. While rst=1, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, instr_done, illegal_op forced 0; all other outputs 0 from the edge on. Reset mid-instruction, including a pending memory wait, aborts it with no count increment.
- Latency with mem_ready=1 each wait: R-type 4, lw 5, sw 4, beq 3, j 3, illegal 2 cycles. Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Strobes are combinational from state (plus mem_ready in FETCH/MEMWR); state, op_q and instr_count are registered.

## Configuration
- MULTICYCLE_JUMP_EN defined: opcode 000010 -> JUMP state, retires in 3 cycles. Undefined: JUMP state is absent, 000010 is illegal (illegal_op pulse, NOP) and PCSrc never equals 10.

## Structure
- Package mc_ctrl_pkg: state enum (4-bit), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J), ALUOp and ALUSrcB/PCSrc encoding constants.
- Sub-module mc_output_decode: pure state(+mem_ready) -> strobe decode; the top level holds the state register, op_q, next-state logic and counter.

## Test plan
- Reset 3 cycles, release, mem_ready=1, opcode=000000 -> states FETCH,DECODE,EXEC,ALUWB; RegWrite=1,RegDst=1 only in ALUWB; instr_count=1.
- lw (100011) with mem_ready low 2 cycles in MEMRD -> 7 cycles total, MemtoReg=1 in MEMWB, one instr_done.
- sw (101011), mem_ready=1 -> MemWrite=1 exactly one cycle, IorD=1, no RegWrite, 4 cycles.
- beq (000100) -> BRANCH with ALUOp=01, PCSrc=01, Branch=1; opcode changed to 000000 during BRANCH does not alter path.
- opcode 111111 -> illegal_op pulse in DECODE, back to FETCH, count+1; with macro undefined, 000010 behaves identically; with macro, PCSrc=10,PCWrite=1.
- Assert rst during MEMRD wait -> FETCH next cycle, MemRead forced 0 during rst, instr_count=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// state encoding, supported opcodes and datapath select encodings.
// Optional feature macro: MULTICYCLE_JUMP_EN (adds the JUMP state and j opcode).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8
`ifdef MULTICYCLE_JUMP_EN
        ,
        S_JUMP   = 4'd9
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True when the opcode has an execute path in this build.
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ: legal = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
            OP_J:                           legal = 1'b1;
`endif
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore strobe decode: maps the sequencer state (plus mem_ready where the
// handshake completes a phase) to the datapath controls for this cycle.
// Optional feature macro: MULTICYCLE_JUMP_EN.
import mc_ctrl_pkg::*;

module mc_output_decode (
    input  state_e     state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       memto_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic       branch,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       done
);

    // Per-state strobe table; everything not named for a state stays low.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        memto_reg = 1'b0;
        reg_dst   = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        branch    = 1'b0;
        alu_src_b = SRCB_REGB;
        alu_op    = ALUOP_ADD;
        pc_src    = PCSRC_ALU;
        done      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                memto_reg = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                done      = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
                done      = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                done     = 1'b1;
            end
`endif
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer top: state register, latched opcode,
// next-state logic and retired-instruction counter. Strobes come from
// mc_output_decode and are held low while reset is asserted.
// Optional feature macro: MULTICYCLE_JUMP_EN (j opcode gets its own JUMP state).
import mc_ctrl_pkg::*;

module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        Branch,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        instr_done,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    state_e      state_r;
    state_e      state_nxt_s;
    logic [5:0]  op_q_r;
    logic [31:0] instr_count_r;

    logic        dec_pcwrite_s;
    logic        dec_irwrite_s;
    logic        dec_iord_s;
    logic        dec_memread_s;
    logic        dec_memwrite_s;
    logic        dec_memtoreg_s;
    logic        dec_regdst_s;
    logic        dec_regwrite_s;
    logic        dec_alusrca_s;
    logic        dec_branch_s;
    logic [1:0]  dec_alusrcb_s;
    logic [1:0]  dec_aluop_s;
    logic [1:0]  dec_pcsrc_s;
    logic        dec_done_s;
    logic        illegal_s;
    logic        done_s;

    mc_output_decode u_decode (
        .state     (state_r),
        .mem_ready (mem_ready),
        .pc_write  (dec_pcwrite_s),
        .ir_write  (dec_irwrite_s),
        .iord      (dec_iord_s),
        .mem_read  (dec_memread_s),
        .mem_write (dec_memwrite_s),
        .memto_reg (dec_memtoreg_s),
        .reg_dst   (dec_regdst_s),
        .reg_write (dec_regwrite_s),
        .alu_src_a (dec_alusrca_s),
        .branch    (dec_branch_s),
        .alu_src_b (dec_alusrcb_s),
        .alu_op    (dec_aluop_s),
        .pc_src    (dec_pcsrc_s),
        .done      (dec_done_s)
    );

    // An unsupported opcode is only judged in DECODE; it retires as a NOP.
    assign illegal_s = (state_r == S_DECODE) && !is_legal_op(opcode);
    assign done_s    = dec_done_s | illegal_s;

    // Next-state selection; after DECODE only the latched opcode steers the path.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt_s = S_MEMADR;
                    OP_RTYPE:     state_nxt_s = S_EXEC;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         state_nxt_s = S_JUMP;
`endif
                    default:      state_nxt_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_q_r == OP_LW) begin
                    state_nxt_s = S_MEMRD;
                end else if (op_q_r == OP_SW) begin
                    state_nxt_s = S_MEMWR;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_nxt_s = S_MEMWB;
                end else begin
                    state_nxt_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_MEMWR;
                end
            end
            S_EXEC:   state_nxt_s = S_ALUWB;
            S_MEMWB:  state_nxt_s = S_FETCH;
            S_ALUWB:  state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            default:  state_nxt_s = S_FETCH;
        endcase
    end

    // State register, opcode latch and retire counter (wraps naturally at 2^32).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FETCH;
            op_q_r        <= 6'd0;
            instr_count_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_DECODE) begin
                op_q_r <= opcode;
            end
            if (done_s) begin
                instr_count_r <= instr_count_r + 32'd1;
            end
        end
    end

    // Output stage: all strobes held low during reset so an aborted access cannot fire.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        Branch     = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (rst) begin
            instr_done = 1'b0;
        end else begin
            PCWrite    = dec_pcwrite_s;
            IRWrite    = dec_irwrite_s;
            IorD       = dec_iord_s;
            MemRead    = dec_memread_s;
            MemWrite   = dec_memwrite_s;
            MemtoReg   = dec_memtoreg_s;
            RegDst     = dec_regdst_s;
            RegWrite   = dec_regwrite_s;
            ALUSrcA    = dec_alusrca_s;
            Branch     = dec_branch_s;
            ALUSrcB    = dec_alusrcb_s;
            ALUOp      = dec_aluop_s;
            PCSrc      = dec_pcsrc_s;
            instr_done = done_s;
            illegal_op = illegal_s;
        end
    end

    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded from its phase
// description into a per-cycle schedule of (mem_ready, opcode, expected strobes),
// then played against the DUT with immediate-assertion checks every cycle.
module tb_multicycle_control;

`ifdef MULTICYCLE_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic        RegDst, RegWrite, ALUSrcA, Branch;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic        instr_done, illegal_op;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;
    int model_count = 0;

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic [17:0] exp;
    } cyc_t;

    cyc_t sched[$];

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .instr_done(instr_done), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] outs();
        return {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, Branch, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op};
    endfunction

    // Strobe vector in the same field order as outs().
    function automatic logic [17:0] vec(input logic pcw, input logic irw, input logic iord,
                                        input logic mrd, input logic mwr, input logic m2r,
                                        input logic rdst, input logic rw, input logic asa,
                                        input logic br, input logic [1:0] asb,
                                        input logic [1:0] aop, input logic [1:0] pcs,
                                        input logic done, input logic ill);
        return {pcw, irw, iord, mrd, mwr, m2r, rdst, rw, asa, br, asb, aop, pcs, done, ill};
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (JUMP_EN && op == 6'b000010);
    endfunction

    task automatic push(input logic rdy, input logic [5:0] op, input logic [17:0] exp);
        cyc_t c;
        c.rdy = rdy;
        c.op  = op;
        c.exp = exp;
        sched.push_back(c);
    endtask

    // Expand one instruction into its expected cycles. Non-decode cycles get a
    // scrambled opcode; mem_ready is random wherever the spec says it is ignored.
    task automatic build(input logic [5:0] op, input int fwait, input int mwait);
        bit ill;
        ill = !legal(op);
        for (int i = 0; i < fwait; i++)
            push(1'b0, rnd_op(), vec(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0));
        push(1'b1, rnd_op(), vec(1,1,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0));
        push(rnd_bit(), op, vec(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, ill, ill));
        if (!ill) begin
            if (op == 6'b100011) begin
                push(rnd_bit(), rnd_op(), vec(0,0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, 2'b00, 0,0));
                for (int i = 0; i < mwait; i++)
                    push(1'b0, rnd_op(), vec(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0));
                push(1'b1, rnd_op(), vec(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0));
                push(rnd_bit(), rnd_op(), vec(0,0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 2'b00, 1,0));
            end else if (op == 6'b101011) begin
                push(rnd_bit(), rnd_op(), vec(0,0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, 2'b00, 0,0));
                for (int i = 0; i < mwait; i++)
                    push(1'b0, rnd_op(), vec(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0));
                push(1'b1, rnd_op(), vec(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1,0));
            end else if (op == 6'b000000) begin
                push(rnd_bit(), rnd_op(), vec(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b10, 2'b00, 0,0));
                push(rnd_bit(), rnd_op(), vec(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 1,0));
            end else if (op == 6'b000100) begin
                push(rnd_bit(), rnd_op(), vec(0,0,0,0,0,0,0,0,1,1, 2'b00, 2'b01, 2'b01, 1,0));
            end else begin
                push(rnd_bit(), rnd_op(), vec(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1,0));
            end
        end
    endtask

    // Play up to n scheduled cycles (inputs change on the falling edge, checked 1 later).
    task automatic play(input string tag, input int n);
        int lim;
        logic [17:0] o;
        lim = (n < sched.size()) ? n : sched.size();
        for (int i = 0; i < lim; i++) begin
            mem_ready = sched[i].rdy;
            opcode    = sched[i].op;
            #1;
            o = outs();
            checks++;
            assert (o === sched[i].exp) else begin
                errors++;
                $error("FAIL %s strobes cyc%0d observed=%b expected=%b", tag, i, o, sched[i].exp);
            end
            checks++;
            assert (instr_count === 32'(model_count)) else begin
                errors++;
                $error("FAIL %s count cyc%0d observed=%0d expected=%0d", tag, i, instr_count, model_count);
            end
            if (sched[i].exp[1]) model_count++;
            @(negedge clk);
        end
        sched.delete();
    endtask

    task automatic run(input string tag, input logic [5:0] op, input int fwait, input int mwait);
        build(op, fwait, mwait);
        play(tag, 1000);
    endtask

    // While reset is high every output is 0; counter is 0 once an edge has passed.
    task automatic check_reset(input string tag);
        logic [17:0] o;
        #1;
        o = outs();
        checks++;
        assert (o === 18'd0) else begin
            errors++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, o, 18'd0);
        end
        checks++;
        assert (instr_count === 32'd0) else begin
            errors++;
            $error("FAIL %s count observed=%0d expected=0", tag, instr_count);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] rop;
        int sel;
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b000000;
        repeat (3) @(negedge clk);
        check_reset("reset_hold");
        rst = 1'b0;
        model_count = 0;

        // Directed cases from the phase descriptions.
        run("rtype", 6'b000000, 0, 0);
        run("lw_wait2", 6'b100011, 0, 2);
        run("sw", 6'b101011, 0, 0);
        run("beq", 6'b000100, 0, 0);
        run("illegal_3f", 6'b111111, 0, 0);
        run("j_or_illegal", 6'b000010, 0, 0);
        run("fetch_wait", 6'b000000, 3, 0);
        run("sw_wait", 6'b101011, 1, 3);

        // Randomized instruction stream with random memory waits.
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: rop = 6'b000000;
                1: rop = 6'b100011;
                2: rop = 6'b101011;
                3: rop = 6'b000100;
                4: rop = 6'b000010;
                default: rop = rnd_op();
            endcase
            run("random", rop, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset during a pending MEMRD wait: fetch, decode, memadr, two wait cycles.
        build(6'b100011, 0, 6);
        play("lw_abort", 5);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        assert (outs() === 18'd0) else begin
            errors++;
            $error("FAIL abort_forced strobes observed=%b expected=%b", outs(), 18'd0);
        end
        @(negedge clk);
        check_reset("abort_reset");
        rst = 1'b0;
        model_count = 0;
        run("after_abort", 6'b000000, 0, 0);
        run("after_abort_lw", 6'b100011, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
